// File: rtl/cchip_pkg.sv
// Shared definitions for the C-chip bus bridge: FSM states, byte-lane
// placement and the default open-bus value.
package cchip_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WAIT,
        ST_ACK,
        ST_RELEASE
    } cchip_state_t;

    // The chip's 8-bit data bus sits on the odd (LDSn) byte lane.
    localparam bit         CCHIP_DATA_LANE_LOW = 1'b1;
    localparam logic [7:0] CCHIP_OPEN_BUS      = 8'hFF;

    // Place a chip byte on its lane and fill the other lane with open-bus.
    function automatic logic [15:0] cchip_place_byte(input logic [7:0] data,
                                                     input logic [7:0] open_bus);
        return CCHIP_DATA_LANE_LOW ? {open_bus, data} : {data, open_bus};
    endfunction

endpackage

// File: rtl/cchip_bus_bridge.sv
// 68000 word bus to C-chip (TC0030CMD) byte interface bridge. One chip
// access per address-strobe cycle, programmable wait states, and a timeout
// that force-acknowledges the CPU if the chip never answers.
module cchip_bus_bridge
    import cchip_pkg::*;
#(
    parameter int         WAIT_CYCLES = 2,
    parameter int         TIMEOUT     = 64,
    parameter logic [7:0] OPEN_BUS    = CCHIP_OPEN_BUS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        sel,
    input  logic        cpu_ASn,
    input  logic        cpu_RW,
    input  logic        cpu_UDSn,
    input  logic        cpu_LDSn,
    input  logic [10:0] cpu_addr,
    input  logic [15:0] cpu_din,
    output logic [15:0] cpu_dout,
    output logic        cpu_DTACKn,
    output logic        timeout_err,
    output logic        chip_CSn,
    output logic        chip_RW,
    output logic [10:0] chip_A,
    output logic [7:0]  chip_Din,
    input  logic [7:0]  chip_Dout,
    input  logic        chip_DTACKn
);

    localparam int             CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  WAIT_CNT = CW'(WAIT_CYCLES);
    localparam logic [CW-1:0]  TO_CNT   = CW'(TIMEOUT);
    localparam logic [CW-1:0]  CNT_MAX  = '1;

    cchip_state_t  state, state_next;
    logic [CW-1:0] cnt, cnt_inc;
    logic          rw_reg;
    logic          latch_req, dout_load, set_timeout;
    logic [15:0]   dout_next;
    logic          start, lane_n;
    logic [7:0]    wr_byte;

    assign lane_n  = CCHIP_DATA_LANE_LOW ? cpu_LDSn : cpu_UDSn;
    assign wr_byte = CCHIP_DATA_LANE_LOW ? cpu_din[7:0] : cpu_din[15:8];
    assign start   = sel && !cpu_ASn && (!cpu_UDSn || !cpu_LDSn);

    // Saturating increment: the counter never wraps back into the wait window.
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

    // Chip select covers SETUP and WAIT only; RW is low only inside a write select.
    assign chip_CSn   = !(state == ST_SETUP || state == ST_WAIT);
    assign chip_RW    = chip_CSn | rw_reg;
    assign cpu_DTACKn = (state != ST_ACK);

    // State register; reset is not gated by ce so it aborts any cycle at once.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (reset)   state <= ST_IDLE;
        else if (ce) state <= state_next;
    end

    // Wait/timeout counter: cleared in SETUP, advanced on each WAIT edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (ce) begin
            if (state == ST_SETUP)     cnt <= '0;
            else if (state == ST_WAIT) cnt <= cnt_inc;
        end
    end

    // Next-state and datapath load requests. The wait comparison uses the
    // post-increment count so WAIT_CYCLES equals the number of WAIT edges.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_next  = state;
        latch_req   = 1'b0;
        dout_load   = 1'b0;
        dout_next   = cpu_dout;
        set_timeout = 1'b0;
        if (ce) begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (!lane_n) begin
                            latch_req  = 1'b1;
                            state_next = ST_SETUP;
                        end else begin
                            if (cpu_RW) begin
                                dout_load = 1'b1;
                                dout_next = {OPEN_BUS, OPEN_BUS};
                            end
                            state_next = ST_ACK;
                        end
                    end
                end
                ST_SETUP: state_next = cpu_ASn ? ST_RELEASE : ST_WAIT;
                ST_WAIT: begin
                    if (cpu_ASn) begin
                        state_next = ST_RELEASE;
                    end else if (cnt_inc >= WAIT_CNT && !chip_DTACKn) begin
                        dout_load  = rw_reg;
                        dout_next  = cchip_place_byte(chip_Dout, OPEN_BUS);
                        state_next = ST_ACK;
                    end else if (cnt_inc >= TO_CNT) begin
                        dout_load   = rw_reg;
                        dout_next   = 16'hFFFF;
                        set_timeout = 1'b1;
                        state_next  = ST_ACK;
                    end
                end
                ST_ACK:     if (cpu_ASn) state_next = ST_RELEASE;
                ST_RELEASE: state_next = ST_IDLE;
                default:    state_next = ST_IDLE;
            endcase
        end
    end

    // Address/data/direction latches, CPU read data and the sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            chip_A      <= '0;
            chip_Din    <= '0;
            rw_reg      <= 1'b1;
            cpu_dout    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (latch_req) begin
                chip_A   <= cpu_addr;
                chip_Din <= wr_byte;
                rw_reg   <= cpu_RW;
            end
            if (dout_load)   cpu_dout    <= dout_next;
            if (set_timeout) timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cchip_bus_bridge.sv
// Self-checking bench for cchip_bus_bridge: directed scenarios plus random
// accesses, all predicted from a latency/data model of the bridge's rules.
module tb_cchip_bus_bridge;

    localparam int         WAIT_CYCLES = 2;
    localparam int         TIMEOUT     = 64;
    localparam logic [7:0] OPEN_BUS    = 8'hFF;

    logic        clk = 1'b0;
    logic        reset, ce, sel, cpu_ASn, cpu_RW, cpu_UDSn, cpu_LDSn;
    logic [10:0] cpu_addr;
    logic [15:0] cpu_din, cpu_dout;
    logic        cpu_DTACKn, timeout_err, chip_CSn, chip_RW;
    logic [10:0] chip_A;
    logic [7:0]  chip_Din, chip_Dout;
    logic        chip_DTACKn;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state: last value the CPU should read back, sticky timeout flag.
    logic [15:0] m_dout;
    bit          m_terr;

    cchip_bus_bridge #(
        .WAIT_CYCLES(WAIT_CYCLES),
        .TIMEOUT    (TIMEOUT),
        .OPEN_BUS   (OPEN_BUS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ce         (ce),
        .sel        (sel),
        .cpu_ASn    (cpu_ASn),
        .cpu_RW     (cpu_RW),
        .cpu_UDSn   (cpu_UDSn),
        .cpu_LDSn   (cpu_LDSn),
        .cpu_addr   (cpu_addr),
        .cpu_din    (cpu_din),
        .cpu_dout   (cpu_dout),
        .cpu_DTACKn (cpu_DTACKn),
        .timeout_err(timeout_err),
        .chip_CSn   (chip_CSn),
        .chip_RW    (chip_RW),
        .chip_A     (chip_A),
        .chip_Din   (chip_Din),
        .chip_Dout  (chip_Dout),
        .chip_DTACKn(chip_DTACKn)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        sel      = 1'b0;
        cpu_ASn  = 1'b1;
        cpu_RW   = 1'b1;
        cpu_UDSn = 1'b1;
        cpu_LDSn = 1'b1;
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_csn"},   chip_CSn,    1);
        check({pfx, "_rw"},    chip_RW,     1);
        check({pfx, "_a"},     chip_A,      0);
        check({pfx, "_din"},   chip_Din,    0);
        check({pfx, "_dtack"}, cpu_DTACKn,  1);
        check({pfx, "_dout"},  cpu_dout,    0);
        check({pfx, "_terr"},  timeout_err, 0);
    endtask

    // One complete AS cycle. The chip answers from ce edge number d onward
    // (edge 1 is the one that samples the start condition).
    task automatic access(input logic [10:0] addr, input bit rd, input bit udsn,
                          input bit ldsn, input logic [15:0] din,
                          input logic [7:0] cdout, input int d, input bit ce_rand);
        int  edges;
        int  exp_edge;
        int  lat;
        bit  to;
        bit  saw_cs;
        bit  ce_now;
        edges  = 0;
        saw_cs = 0;
        to     = 0;
        // Latency: one SETUP edge, then WAIT until both the wait window has
        // elapsed and the chip is ready, capped by the timeout.
        if (ldsn) begin
            exp_edge = 1;
            if (rd) m_dout = {OPEN_BUS, OPEN_BUS};
        end else begin
            lat      = (d > 2 + WAIT_CYCLES) ? d : 2 + WAIT_CYCLES;
            to       = (lat > 2 + TIMEOUT);
            exp_edge = to ? 2 + TIMEOUT : lat;
            if (rd) m_dout = to ? 16'hFFFF : {OPEN_BUS, cdout};
            if (to) m_terr = 1;
        end

        sel         = 1'b1;
        cpu_ASn     = 1'b0;
        cpu_RW      = rd;
        cpu_UDSn    = udsn;
        cpu_LDSn    = ldsn;
        cpu_addr    = addr;
        cpu_din     = din;
        chip_Dout   = cdout;
        ce          = ce_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        chip_DTACKn = !(1 >= d);
        for (int n = 0; n < 600; n++) begin
            ce_now = ce;
            tick();
            if (ce_now) edges++;
            if (!chip_CSn && !saw_cs) begin
                saw_cs = 1;
                check("cs_addr", chip_A, addr);
                check("cs_rw", chip_RW, rd);
                if (!rd) check("cs_wdata", chip_Din, din[7:0]);
            end
            if (!cpu_DTACKn) break;
            ce          = ce_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            chip_DTACKn = !(edges + 1 >= d);
        end
        check("ack_seen", cpu_DTACKn, 0);
        check("ack_edge", edges, exp_edge);
        check("chip_access", saw_cs, !ldsn);
        check("ack_dout", cpu_dout, m_dout);
        check("ack_csn", chip_CSn, 1);
        check("ack_rw", chip_RW, 1);
        check("ack_terr", timeout_err, m_terr);

        // Hold AS low with sel high: ACK must persist and no new access start.
        ce = 1'b1;
        repeat (3) tick();
        check("hold_dtack", cpu_DTACKn, 0);
        check("hold_csn", chip_CSn, 1);
        check("hold_dout", cpu_dout, m_dout);
        cpu_ASn  = 1'b1;
        cpu_UDSn = 1'b1;
        cpu_LDSn = 1'b1;
        tick();
        check("rel_dtack", cpu_DTACKn, 1);
        tick();
        check("idle_csn", chip_CSn, 1);
        idle_bus();
        chip_DTACKn = 1'b1;
    endtask

    initial begin
        bit          rd;
        bit          udsn, ldsn;
        int          d;
        int          s;
        bit          bad;
        logic [7:0]  cd;

        idle_bus();
        reset       = 1'b1;
        ce          = 1'b0;
        cpu_addr    = '0;
        cpu_din     = '0;
        chip_Dout   = '0;
        chip_DTACKn = 1'b1;
        m_dout      = '0;
        m_terr      = 0;
        repeat (3) tick();
        reset = 1'b0;
        ce    = 1'b1;
        tick();
        check_reset_values("rst");

        // Word read, chip ready immediately: ACK on the 4th ce edge.
        access(11'h005, 1, 0, 0, 16'h0000, 8'h5A, 0, 0);
        // LDS byte write at the top of the window.
        access(11'h3FF, 0, 1, 0, 16'h12C3, 8'h00, 0, 0);
        // UDS-only read: no chip access, open bus on both lanes.
        access(11'h123, 1, 0, 1, 16'h0000, 8'h77, 0, 0);

        // Random accesses with random ce gating and chip response time.
        for (int i = 0; i < 14; i++) begin
            rd = $urandom_range(0, 1);
            s  = $urandom_range(0, 2);
            udsn = (s == 1);
            ldsn = (s == 2);
            d  = ($urandom_range(0, 3) == 0) ? $urandom_range(60, 90) : $urandom_range(0, 12);
            cd = 8'($urandom);
            access(11'($urandom), rd, udsn, ldsn, 16'($urandom), cd, d, 1);
        end

        // Chip never answers: forced ACK, then the flag survives a normal cycle.
        access(11'h040, 1, 0, 0, 16'h0000, 8'h11, 1000, 0);
        check("terr_set", timeout_err, 1);
        access(11'h041, 1, 1, 0, 16'h0000, 8'h22, 0, 0);
        check("terr_sticky", timeout_err, 1);

        // AS withdrawn in WAIT: select released, never acknowledged.
        sel = 1'b1; cpu_ASn = 1'b0; cpu_RW = 1'b1; cpu_UDSn = 1'b0; cpu_LDSn = 1'b0;
        cpu_addr = 11'h2AA; chip_DTACKn = 1'b1; ce = 1'b1;
        repeat (4) tick();
        check("abort_cs_active", chip_CSn, 0);
        cpu_ASn = 1'b1; cpu_UDSn = 1'b1; cpu_LDSn = 1'b1;
        tick();
        check("abort_csn", chip_CSn, 1);
        bad = 0;
        repeat (6) begin
            tick();
            if (!cpu_DTACKn || !chip_CSn) bad = 1;
        end
        check("abort_no_ack", bad, 0);
        check("abort_terr", timeout_err, m_terr);
        idle_bus();
        access(11'h155, 1, 0, 0, 16'h0000, 8'hA5, 5, 0);

        // ce stalled mid-WAIT: nothing moves; then reset while in ACK.
        sel = 1'b1; cpu_ASn = 1'b0; cpu_RW = 1'b1; cpu_UDSn = 1'b1; cpu_LDSn = 1'b0;
        cpu_addr = 11'h010; chip_Dout = 8'h3C; chip_DTACKn = 1'b1; ce = 1'b1;
        repeat (3) tick();
        ce = 1'b0;
        chip_DTACKn = 1'b0;
        bad = 0;
        repeat (10) begin
            tick();
            if (!cpu_DTACKn || chip_CSn) bad = 1;
        end
        check("stall_frozen", bad, 0);
        ce = 1'b1;
        tick();
        check("stall_resume_ack", cpu_DTACKn, 0);
        check("stall_dout", cpu_dout, {OPEN_BUS, 8'h3C});
        ce    = 1'b0;
        reset = 1'b1;
        tick();
        check_reset_values("midrst");
        reset = 1'b0;
        idle_bus();
        ce = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
